// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional feature macro ID_EX_PERF_CNT_EN adds stall/flush event counters.
module id_ex_stage #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              flush_i,
    input  logic              hold_i,
    input  logic [4:0]        id_rs1_addr_i,
    input  logic [4:0]        id_rs2_addr_i,
    input  logic [4:0]        id_rd_addr_i,
    input  logic [DATA_W-1:0] id_rs1_data_i,
    input  logic [DATA_W-1:0] id_rs2_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [8:0]        id_ctrl_i,
    output logic [4:0]        ex_rs1_addr_o,
    output logic [4:0]        ex_rs2_addr_o,
    output logic [4:0]        ex_rd_addr_o,
    output logic [DATA_W-1:0] ex_rs1_data_o,
    output logic [DATA_W-1:0] ex_rs2_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [8:0]        ex_ctrl_o,
    output logic              ex_valid_o,
    output logic              pc_write_en_o,
    output logic              if_id_write_en_o
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    // ctrl packing: {reg_write, mem_read, mem_write, mem_2_reg, alu_src, branch, jump, alu_op[1:0]}
    localparam int CTRL_MEM_READ = 7;

    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic insert_bubble;
    logic advance_en;

    // rs2 is compared even for formats that do not read it: a false stall is harmless.
    assign rs1_hit  = (ex_rd_addr_o == id_rs1_addr_i);
    assign rs2_hit  = (ex_rd_addr_o == id_rs2_addr_i);
    assign load_use = ex_valid_o & ex_ctrl_o[CTRL_MEM_READ]
                    & (ex_rd_addr_o != 5'd0) & (rs1_hit | rs2_hit);

    // A flush discards the ID instruction anyway, so there is nothing to stall for.
    assign pc_write_en_o    = ~(load_use & ~flush_i) & ~hold_i;
    assign if_id_write_en_o = ~(load_use & ~flush_i) & ~hold_i;

    assign advance_en    = ~hold_i;
    assign insert_bubble = flush_i | load_use;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            ex_rs1_addr_o <= '0;
            ex_rs2_addr_o <= '0;
            ex_rd_addr_o  <= '0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_imm_o      <= '0;
            ex_ctrl_o     <= '0;
            ex_valid_o    <= 1'b0;
        end else if (advance_en) begin
            ex_rs1_addr_o <= id_rs1_addr_i;
            ex_rs2_addr_o <= id_rs2_addr_i;
            ex_rd_addr_o  <= id_rd_addr_i;
            ex_rs1_data_o <= id_rs1_data_i;
            ex_rs2_data_o <= id_rs2_data_i;
            ex_imm_o      <= id_imm_i;
            // Zero ctrl means no reg_write/mem_read/mem_write, so forwarding never matches a bubble.
            if (insert_bubble) begin
                ex_ctrl_o  <= '0;
                ex_valid_o <= 1'b0;
            end else begin
                ex_ctrl_o  <= id_ctrl_i;
                ex_valid_o <= 1'b1;
            end
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else if (advance_en) begin
            if (flush_i)
                flush_cnt_o <= flush_cnt_o + 32'd1;
            else if (load_use)
                stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule
